// File: rtl/sum_kpg_pipe.sv
// Pipelined adder/subtractor with a Kogge-Stone KPG carry network split across
// STAGES register boundaries and a valid/ready handshake driven by one advance enable.
module sum_kpg_pipe #(
    parameter int WIDTH  = 22,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       kIn,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf,
    output logic             kerr
);

    localparam int LEVELS = $clog2(WIDTH);

    // Per-stage payload: group generate/propagate, original half-sum bits and side info
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] x;
        logic             cin;
        logic             a_msb;
        logic             b_msb;
        logic             kerr;
    } stage_t;

    function automatic stage_t prefix_levels(input stage_t s_in, input int lo, input int hi);
        stage_t           s_out;
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;
        s_out = s_in;
        for (int k = 0; k < LEVELS; k++) begin
            if (k >= lo && k < hi) begin
                g_n = s_out.g;
                p_n = s_out.p;
                for (int i = (1 << k); i < WIDTH; i++) begin
                    g_n[i] = s_out.g[i] | (s_out.p[i] & s_out.g[i - (1 << k)]);
                    p_n[i] = s_out.p[i] & s_out.p[i - (1 << k)];
                end
                s_out.g = g_n;
                s_out.p = p_n;
            end
        end
        return s_out;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] prop0;
    logic [WIDTH-1:0] gen0;
    logic             cin0;
    logic             kerr0;
    stage_t           head;

    assign b_eff = sub ? ~b : b;
    assign cin0  = sub | (kIn == 2'b11);
    assign kerr0 = !sub && (kIn[1] ^ kIn[0]);
    assign prop0 = a ^ b_eff;
    // Carry-in is folded into bit 0's generate so the prefix tree needs no extra column
    assign gen0  = (a & b_eff) | {{(WIDTH-1){1'b0}}, prop0[0] & cin0};
    assign head  = '{g: gen0, p: prop0, x: prop0, cin: cin0,
                     a_msb: a[WIDTH-1], b_msb: b_eff[WIDTH-1], kerr: kerr0};

    stage_t st_reg [STAGES];
    stage_t st_nxt [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * LEVELS / STAGES;
            localparam int HI = (gi + 1) * LEVELS / STAGES;
            if (gi == 0) begin : g_src
                assign st_nxt[gi] = prefix_levels(head, LO, HI);
            end else begin : g_src
                assign st_nxt[gi] = prefix_levels(st_reg[gi-1], LO, HI);
            end
        end
    endgenerate

    logic [WIDTH-1:0] carry;
    logic [WIDTH:0]   sum_next;
    logic             ovf_next;

    assign carry    = {st_nxt[STAGES-1].g[WIDTH-2:0], st_nxt[STAGES-1].cin};
    assign sum_next = {st_nxt[STAGES-1].g[WIDTH-1], st_nxt[STAGES-1].x ^ carry};
    assign ovf_next = (st_nxt[STAGES-1].a_msb == st_nxt[STAGES-1].b_msb) &&
                      (sum_next[WIDTH-1] != st_nxt[STAGES-1].a_msb);

    logic [STAGES-1:0] valid_reg;
    logic [WIDTH:0]    sum_reg;
    logic              ovf_reg;
    logic              kerr_reg;

    assign out_valid = valid_reg[STAGES-1];
    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign sum       = sum_reg;
    assign ovf       = ovf_reg;
    assign kerr      = kerr_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg <= '0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
            kerr_reg  <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                st_reg[s] <= '0;
            end
        end else if (adv) begin
            valid_reg[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                valid_reg[s] <= valid_reg[s-1];
            end
            for (int s = 0; s < STAGES - 1; s++) begin
                st_reg[s] <= st_nxt[s];
            end
            sum_reg  <= sum_next;
            ovf_reg  <= ovf_next;
            kerr_reg <= st_nxt[STAGES-1].kerr;
        end
    end

endmodule
